acc16_dmem_resp: RTL

data-memory responder serving the accumulator core's direct and indirect operand accesses over a valid/ready request/response handshake.

Interface
REQ-001 Parameter DW, default 16, data word width.
REQ-002 Parameter AW, default 10, address width (operand field IR[9:0]).
REQ-003 Parameter DEPTH, default 623, number of data words (1024 - 401).
REQ-004 clk1  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  responder accepts request this cycle.
REQ-008 req_addr  input  AW  operand address.
REQ-009 req_ind  input  1  1 = indirect (mem[mem[addr]]), 0 = direct (mem[addr]).
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_wdata  input  DW  write data.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  requester accepts response.
REQ-014 rsp_data  output  DW  read data, or echoed write data on writes.
REQ-015 rsp_err  output  1  address or pointer out of range.
REQ-016 req_count  output  16  count of completed responses, wraps at 0xFFFF -> 0x0000.

Function
REQ-017 FSM states IDLE, PTR, ACC, RESP; req_ready SHALL equal (state == IDLE).
REQ-018 Accept: req_valid && req_ready at an edge latches addr/ind/we/wdata; direct -> ACC, indirect -> PTR.
REQ-019 PTR: one cycle reading mem[addr]; effective address = mem[addr][AW-1:0]; next state ACC.
REQ-020 ACC: read -> rsp_data <= mem[effective addr]; write -> mem[effective addr] <= wdata, rsp_data <= wdata; next state RESP.
REQ-021 Latency: rsp_valid rises 2 edges after the accept edge (direct) and 3 edges after it (indirect).
REQ-022 RESP: rsp_valid = 1; rsp_data/rsp_err held stable until rsp_valid && rsp_ready, then IDLE and req_count += 1.
REQ-023 A new request is not accepted in the same cycle a response completes; earliest accept is the following cycle.
REQ-024 Range: req_addr >= DEPTH -> no memory access, go directly to RESP with rsp_err = 1, rsp_data = 0.
REQ-025 Indirect: pointer value >= DEPTH (or pointer upper bits beyond AW nonzero) -> no access, RESP with rsp_err = 1, rsp_data = 0.
REQ-026 Errored accesses SHALL leave memory unmodified and still increment req_count.
REQ-027 Memory reads are synchronous (one-cycle); a write in ACC is visible to any later-accepted request.
REQ-028 Inputs other than rsp_ready are ignored outside IDLE.

Reset
REQ-029 rst low SHALL immediately force state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, req_count 0; req_ready is 1 after release.
REQ-030 Memory contents SHALL NOT be affected by reset.
REQ-031 Reset asserted in PTR or ACC SHALL abort the access; a write not yet performed SHALL NOT occur.

Verification
REQ-032 Direct write addr 5 data 0x1234, then direct read addr 5 -> rsp_data 0x1234, rsp_err 0, rsp_valid 2 edges after accept.
REQ-033 mem[10] = 20, mem[20] = 0xBEEF; indirect read addr 10 -> rsp_data 0xBEEF, rsp_valid 3 edges after accept.
REQ-034 Direct read addr 700 -> rsp_err 1, rsp_data 0; indirect read via pointer 650 -> rsp_err 1, target unmodified on indirect write.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready 0, req_valid ignored; completion increments req_count by 1.
REQ-036 Indirect write mem[mem[3]] with rst pulsed low during PTR -> outputs cleared immediately, target word unchanged, req_count 0.
REQ-037 0x10000 completed responses -> req_count wraps to 0x0000.

---
 rtl/acc16_dmem_resp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/acc16_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : acc16_dmem_resp
// Brief    : Data-memory responder for the accumulator core; serves direct and
//            indirect operand reads/writes over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module acc16_dmem_resp #(
  parameter int DW    = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 623
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_ind,
  input  logic          req_we,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [15:0]   req_count
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PTR  = 2'd1,
    S_ACC  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_ptr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rsp_data;
  logic [AW-1:0] r_eff;
  logic          r_we;
  logic          r_rsp_err;
  logic [15:0]   r_req_count;
  logic          w_accept;
  logic          w_addr_oob;
  logic          w_ptr_hi_nz;
  logic          w_ptr_bad;

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign req_count  = r_req_count;
  assign w_accept   = req_valid && req_ready;
  assign w_addr_oob = ({1'b0, req_addr} >= c_DEPTH);

  // A pointer whose bits above the address field are set is out of range too.
  generate
    if (DW > AW) begin : g_ptr_hi
      assign w_ptr_hi_nz = |r_ptr[DW-1:AW];
    end else begin : g_ptr_nohi
      assign w_ptr_hi_nz = 1'b0;
    end
  endgenerate

  assign w_ptr_bad = w_ptr_hi_nz || ({1'b0, r_ptr[AW-1:0]} >= c_DEPTH);

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_addr_oob ? S_RESP : (req_ind ? S_PTR : S_ACC);
      S_PTR:  w_next = w_ptr_bad ? S_RESP : S_ACC;
      S_ACC:  w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_eff       <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_req_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_eff   <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            if (w_addr_oob) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        S_PTR: begin
          r_eff <= r_ptr[AW-1:0];
          if (w_ptr_bad) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_ACC: begin
          r_rsp_err  <= 1'b0;
          r_rsp_data <= r_we ? r_wdata : r_mem[r_eff];
        end
        S_RESP: if (rsp_ready) r_req_count <= r_req_count + 16'd1;
        default: ;
      endcase
    end
  end

  // Storage is never reset; the pointer word is fetched on the accept edge so
  // that it is available throughout the PTR cycle.
  always_ff @(posedge clk1) begin
    if (w_accept && !w_addr_oob) r_ptr <= r_mem[req_addr];
    if (r_state == S_ACC && r_we) r_mem[r_eff] <= r_wdata;
  end

endmodule
`default_nettype wire
